// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and elaboration-time helpers for the camera power sequencer.
package cam_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_UP_WAIT   = 3'd1,
    ST_ON        = 3'd2,
    ST_DOWN_WAIT = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Microseconds to clock ticks, never less than one tick.
  function automatic logic [63:0] us_to_ticks(input logic [63:0] us,
                                              input logic [63:0] clk_freq);
    logic [63:0] t;
    t = (us * clk_freq) / 64'd1_000_000;
    return (t == 64'd0) ? 64'd1 : t;
  endfunction

  // Counter width able to hold the largest tick count.
  function automatic int cnt_width(input logic [63:0] max_ticks);
    return $clog2(max_ticks) + 1;
  endfunction

endpackage

// File: rtl/cam_pwr_seq_delay_cnt.sv
// Loadable down-counter; done_o is high once the loaded count has run out.
// A load of N makes done_o rise N cycles later, so a decision taken on done_o
// lands exactly N edges after the load edge.
module pwr_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/cam_pwr_seq.sv
// Multi-rail camera power sequencer: ordered enable with per-stage settle
// delay, reverse-order disable with a fixed gap, immediate shutdown on fault.
// Optional macro CAM_PWR_SEQ_PGOOD_EN adds per-stage power-good gating with a
// timeout and power-good monitoring while ON.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 74_250_000,
  parameter int unsigned STAGES = 4,
  parameter logic [STAGES-1:0][31:0] DELAY_US = {32'd100_000, 32'd1_000, 32'd1_000, 32'd1_000},
  parameter int unsigned DOWN_DELAY_US = 1_000,
  parameter int unsigned PGOOD_TIMEOUT_US = 10_000
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic                      fault_i,
  input  logic                      clear_fault_i,
  input  logic [STAGES-1:0]         pgood_i,
  output logic [STAGES-1:0]         en_o,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic                      fault_o,
  output logic [$clog2(STAGES):0]   stage_o
);

  localparam int SW = $clog2(STAGES) + 1;

  // Largest tick count of any delay this block may load.
  function automatic logic [63:0] calc_max_ticks();
    logic [63:0] m;
    m = us_to_ticks(64'(DOWN_DELAY_US), 64'(CLK_FREQ));
    if (us_to_ticks(64'(PGOOD_TIMEOUT_US), 64'(CLK_FREQ)) > m)
      m = us_to_ticks(64'(PGOOD_TIMEOUT_US), 64'(CLK_FREQ));
    for (int i = 0; i < int'(STAGES); i++)
      if (us_to_ticks(64'(DELAY_US[i]), 64'(CLK_FREQ)) > m)
        m = us_to_ticks(64'(DELAY_US[i]), 64'(CLK_FREQ));
    return m;
  endfunction

  localparam logic [63:0]    MAX_TICKS  = calc_max_ticks();
  localparam int             CW         = cnt_width(MAX_TICKS);
  localparam logic [CW-1:0]  DOWN_TICKS = CW'(us_to_ticks(64'(DOWN_DELAY_US), 64'(CLK_FREQ)));
  localparam logic [SW-1:0]  LAST       = SW'(STAGES - 1);
  localparam int             NIDX       = 2 ** SW;

  // Per-stage settle ticks, padded to a power of two so any k_q indexes it.
  logic [CW-1:0] up_ticks [NIDX];
  for (genvar gi = 0; gi < NIDX; gi++) begin : g_ticks
    if (gi < int'(STAGES)) begin : g_used
      assign up_ticks[gi] = CW'(us_to_ticks(64'(DELAY_US[gi]), 64'(CLK_FREQ)));
    end else begin : g_pad
      assign up_ticks[gi] = CW'(1);
    end
  end

  state_e            state_q;
  logic [STAGES-1:0] en_q;
  logic [SW-1:0]     k_q;
  logic              ready_q, busy_q, fault_q;

  logic              dly_load, dly_done;
  logic [CW-1:0]     dly_value;
  logic              fault_now, up_done;
  logic [SW-1:0]     next_idx, prev_idx;

  assign next_idx = (k_q == LAST) ? k_q : k_q + SW'(1);
  assign prev_idx = k_q - SW'(1);

`ifdef CAM_PWR_SEQ_PGOOD_EN
  localparam logic [CW-1:0] PG_TICKS = CW'(us_to_ticks(64'(PGOOD_TIMEOUT_US), 64'(CLK_FREQ)));
  logic pg_k, pg_wait, tmo_done;

  assign pg_k      = |(pgood_i & (STAGES'(1) << k_q));
  assign pg_wait   = (state_q == ST_UP_WAIT) && dly_done && !pg_k;
  assign up_done   = dly_done && pg_k;
  assign fault_now = fault_i
                   | ((state_q == ST_ON) && !(&pgood_i))
                   | (pg_wait && tmo_done);

  // Timeout counter is held loaded until a stage starts waiting on pgood.
  pwr_delay_cnt #(.W(CW)) u_tmo_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (!pg_wait),
    .value_i (PG_TICKS),
    .done_o  (tmo_done)
  );
`else
  logic pgood_unused;
  assign pgood_unused = ^pgood_i;
  assign up_done      = dly_done;
  assign fault_now    = fault_i;
`endif

  pwr_delay_cnt #(.W(CW)) u_dly_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (dly_load),
    .value_i (dly_value),
    .done_o  (dly_done)
  );

  // Delay reloads that accompany each FSM step.
  always_comb begin
    dly_load  = 1'b0;
    dly_value = DOWN_TICKS;
    case (state_q)
      ST_OFF: if (en_i) begin
        dly_load  = 1'b1;
        dly_value = up_ticks[0];
      end
      ST_UP_WAIT: begin
        if (!en_i) begin
          dly_load = 1'b1;
        end else if (up_done && (k_q != LAST)) begin
          dly_load  = 1'b1;
          dly_value = up_ticks[next_idx];
        end
      end
      ST_ON:        if (!en_i) dly_load = 1'b1;
      ST_DOWN_WAIT: if (dly_done && (k_q != '0)) dly_load = 1'b1;
      default: ;
    endcase
  end

  // Sequencer FSM with registered outputs; a fault overrides every state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_OFF;
      en_q    <= '0;
      k_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (fault_now) begin
      state_q <= ST_FAULT;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b1;
    end else begin
      case (state_q)
        ST_OFF: if (en_i) begin
          en_q    <= STAGES'(1);
          k_q     <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_UP_WAIT;
        end
        ST_UP_WAIT: begin
          if (!en_i) begin
            en_q    <= en_q & ~(STAGES'(1) << k_q);
            state_q <= ST_DOWN_WAIT;
          end else if (up_done) begin
            if (k_q == LAST) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_ON;
            end else begin
              en_q <= en_q | (STAGES'(1) << next_idx);
              k_q  <= next_idx;
            end
          end
        end
        ST_ON: if (!en_i) begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          en_q    <= en_q & ~(STAGES'(1) << LAST);
          k_q     <= LAST;
          state_q <= ST_DOWN_WAIT;
        end
        ST_DOWN_WAIT: if (dly_done) begin
          if (k_q != '0) begin
            en_q <= en_q & ~(STAGES'(1) << prev_idx);
            k_q  <= prev_idx;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_OFF;
          end
        end
        ST_FAULT: if (clear_fault_i && !en_i) begin
          fault_q <= 1'b0;
          state_q <= ST_OFF;
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign en_o    = en_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign fault_o = fault_q;
  assign stage_o = k_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq: 1 MHz clock so ticks equal microseconds.
module tb_cam_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, fault, clear;
  logic [2:0] pgood;
  logic [2:0] en_o;
  logic       ready_o, busy_o, fault_o;
  logic [2:0] stage_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_pwr_seq #(
    .CLK_FREQ         (1_000_000),
    .STAGES           (3),
    .DELAY_US         ({32'd30, 32'd20, 32'd10}),
    .DOWN_DELAY_US    (5),
    .PGOOD_TIMEOUT_US (8)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .fault_i       (fault),
    .clear_fault_i (clear),
    .pgood_i       (pgood),
    .en_o          (en_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .fault_o       (fault_o),
    .stage_o       (stage_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; fault = 1'b0; clear = 1'b0; pgood = 3'b111;
    step(); step();
    checks++;
    if ({en_o, ready_o, busy_o, fault_o, stage_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got en=%b rdy=%b busy=%b flt=%b stg=%0d exp all zero",
               en_o, ready_o, busy_o, fault_o, stage_o);
    end
    en = 1'b0; rst_n = 1'b1;
    step();
    checks++;
    if ({en_o, ready_o, busy_o, fault_o, stage_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_release got en=%b rdy=%b busy=%b flt=%b exp all zero",
               en_o, ready_o, busy_o, fault_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_power_up();
    logic [2:0] exp_en, exp_stg;
    en = 1'b1;
    for (int i = 1; i <= 61; i++) begin
      step();
      exp_en  = (i < 11) ? 3'b001 : (i < 31) ? 3'b011 : 3'b111;
      exp_stg = (i < 11) ? 3'd0 : (i < 31) ? 3'd1 : 3'd2;
      checks++;
      if (en_o !== exp_en || busy_o !== (i <= 60) || ready_o !== (i == 61) || stage_o !== exp_stg) begin
        errors++;
        $display("FAIL power_up cyc=%0d got en=%b busy=%b rdy=%b stg=%0d exp en=%b busy=%b rdy=%b stg=%0d",
                 i, en_o, busy_o, ready_o, stage_o, exp_en, (i <= 60), (i == 61), exp_stg);
      end
    end
    $display("test_power_up done");
  endtask

  task automatic test_power_down();
    logic [2:0] exp_en, exp_stg;
    en = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_en  = (i < 6) ? 3'b011 : (i < 11) ? 3'b001 : 3'b000;
      exp_stg = (i < 6) ? 3'd2 : (i < 11) ? 3'd1 : 3'd0;
      checks++;
      if (en_o !== exp_en || busy_o !== (i < 16) || ready_o !== 1'b0 || stage_o !== exp_stg) begin
        errors++;
        $display("FAIL power_down cyc=%0d got en=%b busy=%b rdy=%b stg=%0d exp en=%b busy=%b rdy=0 stg=%0d",
                 i, en_o, busy_o, ready_o, stage_o, exp_en, (i < 16), exp_stg);
      end
    end
    $display("test_power_down done");
  endtask

  task automatic test_abort();
    logic [2:0] exp_en, exp_stg;
    en = 1'b1;
    repeat (15) step();
    checks++;
    if (en_o !== 3'b011) begin
      errors++;
      $display("FAIL abort_pre got en=%b exp 011", en_o);
    end
    en = 1'b0;
    for (int i = 16; i <= 28; i++) begin
      step();
      exp_en  = (i < 21) ? 3'b001 : 3'b000;
      exp_stg = (i < 21) ? 3'd1 : 3'd0;
      checks++;
      if (en_o !== exp_en || busy_o !== (i < 26) || stage_o !== exp_stg) begin
        errors++;
        $display("FAIL abort cyc=%0d got en=%b busy=%b stg=%0d exp en=%b busy=%b stg=%0d",
                 i, en_o, busy_o, stage_o, exp_en, (i < 26), exp_stg);
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_fault();
    en = 1'b1;
    repeat (61) step();
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_pre_ready got %b exp 1", ready_o);
    end
    fault = 1'b1;
    step();
    fault = 1'b0;
    checks++;
    if (en_o !== 3'b000 || fault_o !== 1'b1 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_entry got en=%b flt=%b rdy=%b busy=%b exp en=000 flt=1 rdy=0 busy=0",
               en_o, fault_o, ready_o, busy_o);
    end
    clear = 1'b1;
    step();
    checks++;
    if (fault_o !== 1'b1 || en_o !== 3'b000) begin
      errors++;
      $display("FAIL fault_clear_with_en got flt=%b en=%b exp flt=1 en=000", fault_o, en_o);
    end
    en = 1'b0; fault = 1'b1;
    step();
    checks++;
    if (fault_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_beats_clear got flt=%b exp 1", fault_o);
    end
    fault = 1'b0;
    step();
    checks++;
    if (fault_o !== 1'b0 || en_o !== 3'b000 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_cleared got flt=%b en=%b busy=%b exp flt=0 en=000 busy=0",
               fault_o, en_o, busy_o);
    end
    clear = 1'b0;
    step();
    checks++;
    if (en_o !== 3'b000 || busy_o !== 1'b0 || fault_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_off_idle got en=%b busy=%b flt=%b exp all zero", en_o, busy_o, fault_o);
    end
    $display("test_fault done");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_en;
    logic       exp_busy;
    en = 1'b1;
    repeat (61) step();
    en = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      exp_en   = (i < 6) ? 3'b011 : (i < 11) ? 3'b001 : (i < 17) ? 3'b000 : 3'b001;
      exp_busy = (i != 16);
      checks++;
      if (en_o !== exp_en || busy_o !== exp_busy) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got en=%b busy=%b exp en=%b busy=%b",
                 i, en_o, busy_o, exp_en, exp_busy);
      end
      if (i == 3) en = 1'b1;
    end
    en = 1'b0;
    repeat (12) step();
    checks++;
    if (en_o !== 3'b000 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_settle got en=%b busy=%b exp en=000 busy=0", en_o, busy_o);
    end
    $display("test_back_to_back done");
  endtask

`ifdef CAM_PWR_SEQ_PGOOD_EN
  task automatic test_pgood_timeout();
    pgood = 3'b001;
    en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 11 || (i >= 31 && i <= 36)) begin
        checks++;
        if (en_o !== 3'b011 || fault_o !== 1'b0) begin
          errors++;
          $display("FAIL pgood_wait cyc=%0d got en=%b flt=%b exp en=011 flt=0", i, en_o, fault_o);
        end
      end
    end
    checks++;
    if (en_o !== 3'b000 || fault_o !== 1'b1) begin
      errors++;
      $display("FAIL pgood_timeout got en=%b flt=%b exp en=000 flt=1", en_o, fault_o);
    end
    en = 1'b0; clear = 1'b1; pgood = 3'b111;
    step();
    clear = 1'b0;
    $display("test_pgood_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_fault();
    test_back_to_back();
`ifdef CAM_PWR_SEQ_PGOOD_EN
    test_pgood_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_pwr_seq.md
Name: cam_pwr_seq

Overview:
Parametrised multi-rail camera power sequencer, the successor to the single-pulse power-up timer. It enables STAGES outputs (rails, clock enable, reset release) in order, with a per-stage settle delay after each. It disables them in reverse order with a fixed gap, and forces all outputs off on a fault. It sits beside the CSI-2 receiver and drives the sensor power/reset pins; ready_o gates receiver start.

Parameters:
CLK_FREQ, 74_250_000, clk_i frequency in Hz
STAGES, 4, number of sequenced outputs (1..16)
DELAY_US, {32'd100_000, 32'd1_000, 32'd1_000, 32'd1_000}, packed [STAGES-1:0][31:0]; settle time in us after enabling stage k (index k)
DOWN_DELAY_US, 1_000, gap in us between successive disables
PGOOD_TIMEOUT_US, 10_000, pgood wait limit (used only with CAM_PWR_SEQ_PGOOD_EN)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
en_i  in  1  level request: 1 = power up, 0 = power down
fault_i  in  1  external fault, level
clear_fault_i  in  1  fault clear request
pgood_i  in  STAGES  per-stage power-good; ignored without the macro
en_o  out  STAGES  stage enables, registered
ready_o  out  1  all stages up and last delay elapsed
busy_o  out  1  sequencing in progress (UP_WAIT or DOWN_WAIT)
fault_o  out  1  sticky fault flag
stage_o  out  $clog2(STAGES)+1  current stage index

Behaviour:
- Ticks: ticks(us) = max(1, us*CLK_FREQ/1_000_000), computed in 64-bit at elaboration. Counter width = $clog2 of the largest tick count, plus 1.
- Reset (rst_n_i low, async): state OFF; en_o=0, ready_o=0, busy_o=0, fault_o=0, stage_o=0, counter=0.
- States: OFF, UP_WAIT, ON, DOWN_WAIT, FAULT.
- OFF: en_i=1 and fault_i=0 -> next edge: en_o[0]=1, counter=ticks(DELAY_US[0]), k=0, UP_WAIT. Latency from en_i to en_o[0] is 1 cycle.
- UP_WAIT: counter decrements once per cycle. At expiry:
  - k<STAGES-1: set en_o[k+1], k++, reload ticks(DELAY_US[k+1]).
  - k=STAGES-1: go to ON, ready_o=1.
- UP_WAIT with en_i=0 (abort): next edge clears en_o[k], loads ticks(DOWN_DELAY_US), enters DOWN_WAIT at stage k. Stages above k are never enabled.
- ON: en_i=0 -> next edge ready_o=0, clear en_o[STAGES-1], enter DOWN_WAIT.
- DOWN_WAIT: at expiry:
  - if k>0: k--, clear en_o[k], reload.
  - if k=0: go to OFF.
  - en_i reasserting mid-down is ignored until OFF is reached; OFF then restarts on the following edge if en_i=1.
- Fault: fault_i=1 in any state -> next edge en_o=0, ready_o=0, busy_o=0, fault_o=1, FAULT. No reverse sequencing.
- FAULT: exits to OFF only when clear_fault_i=1, en_i=0 and fault_i=0; fault_o clears on the same edge. fault_i and clear_fault_i high together: fault wins.
- busy_o=1 exactly in UP_WAIT/DOWN_WAIT. ready_o=1 exactly in ON. stage_o=k.

Optional Feature:
CAM_PWR_SEQ_PGOOD_EN
- Defined:
  - In UP_WAIT, after the delay expires, advancing also requires pgood_i[k]=1. A second counter of ticks(PGOOD_TIMEOUT_US) runs while waiting; expiry -> FAULT.
  - In ON, pgood_i any bit 0 -> FAULT next edge.
  - In DOWN_WAIT, pgood_i is ignored.
- Undefined: pgood_i is unused, no timeout logic, and timing is purely delay-based.

Decomposition:
- Package cam_pwr_seq_pkg holds:
  - the state enum
  - function us_to_ticks(us, clk_freq) returning a 64-bit value
  - a cnt_width helper
- Sub-module pwr_delay_cnt: loadable down-counter with load_i, value_i, done_o, one instance for the delay and one for the pgood timeout.

Test Plan:
Bench settings: CLK_FREQ=1_000_000, STAGES=3, DELAY_US={30,20,10} (stage0=10), DOWN_DELAY_US=5, PGOOD_TIMEOUT_US=8.
1. en_i rises at cycle 0 -> en_o=001@1, 011@11, 111@31, ready_o=1@61, busy_o=1 over 1..60.
2. From ON, en_i falls at t -> ready_o=0 and en_o=011@t+1, 001@t+6, 000@t+11, busy_o=0 and OFF@t+16.
3. en_i falls at cycle 15 (en_o=011) -> en_o=001@16, 000@21, OFF@26; en_o[2] never set.
4. fault_i pulse in ON -> en_o=000 and fault_o=1 next edge. clear_fault_i with en_i=1 -> stays in FAULT. Then en_i=0 with clear -> OFF, fault_o=0 next edge.
5. en_i re-rises during DOWN_WAIT -> the down sequence completes to en_o=000 and OFF, then en_o[0]=1 one cycle later.
6. With CAM_PWR_SEQ_PGOOD_EN, pgood_i=001 held -> en_o=011@11, stage 1 delay expires @31, fault_o=1 and en_o=000 @39±1.
